// File: rtl/div_pkg.sv
// Shared types and constants for the multicycle divider: state encoding, widths, sign helper.
package div_pkg;

  localparam int unsigned DIV_WIDTH = 32;
  localparam int unsigned DIV_ITERS = 32;
  localparam int unsigned CNT_WIDTH = $clog2(DIV_ITERS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_e;

  // Two's complement negate when neg is set; 0x80000000 maps to itself (wrap-around).
  function automatic logic [DIV_WIDTH-1:0] cond_negate(input logic [DIV_WIDTH-1:0] val,
                                                       input logic                 neg);
    return neg ? (~val + 1'b1) : val;
  endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in the next dividend bit, trial-subtract.
module div_step
  import div_pkg::*;
(
  input  logic [DIV_WIDTH-1:0] part_rem,
  input  logic                 dvd_bit,
  input  logic [DIV_WIDTH-1:0] dvsr,
  output logic [DIV_WIDTH-1:0] next_rem,
  output logic                 q_bit
);

  logic [DIV_WIDTH:0] shifted;
  logic [DIV_WIDTH:0] diff;

  // part_rem < dvsr always holds, so bit DIV_WIDTH of diff is a clean borrow flag.
  always_comb begin
    shifted  = {part_rem, dvd_bit};
    diff     = shifted - {1'b0, dvsr};
    q_bit    = ~diff[DIV_WIDTH];
    next_rem = q_bit ? diff[DIV_WIDTH-1:0] : shifted[DIV_WIDTH-1:0];
  end

endmodule

// File: rtl/multicycle_divider.sv
// Iterative 32-bit restoring divider (IDLE -> CALC x32 -> FIX -> DONE), 34-cycle latency.
// Signed DIV support is enabled by defining MULTICYCLE_DIVIDER_SIGNED_EN; otherwise all divides are DIVU.
module multicycle_divider
  import div_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_div,
  input  logic                 signed_div,
  input  logic [DIV_WIDTH-1:0] dividend,
  input  logic [DIV_WIDTH-1:0] divisor,
  input  logic                 flush,
  output logic [DIV_WIDTH-1:0] quotient,
  output logic [DIV_WIDTH-1:0] remainder,
  output logic                 done_div,
  output logic                 busy,
  output logic                 DivByZero
);

  div_state_e           state_q, state_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic [DIV_WIDTH-1:0] prem_q, prem_d;
  logic [DIV_WIDTH-1:0] qacc_q, qacc_d;
  logic [DIV_WIDTH-1:0] dvsr_q, dvsr_d;
  logic [DIV_WIDTH-1:0] quotient_q, quotient_d;
  logic [DIV_WIDTH-1:0] remainder_q, remainder_d;
  logic                 neg_quo_q, neg_quo_d;
  logic                 neg_rem_q, neg_rem_d;
  logic                 dbz_q, dbz_d;

  logic                 sgn_mode;
  logic                 dvd_neg, dvs_neg;
  logic [DIV_WIDTH-1:0] step_rem;
  logic                 step_bit;

`ifdef MULTICYCLE_DIVIDER_SIGNED_EN
  assign sgn_mode = signed_div;
`else
  logic unused_signed_div;
  assign unused_signed_div = signed_div;
  assign sgn_mode          = 1'b0;
`endif

  div_step u_div_step (
    .part_rem (prem_q),
    .dvd_bit  (qacc_q[DIV_WIDTH-1]),
    .dvsr     (dvsr_q),
    .next_rem (step_rem),
    .q_bit    (step_bit)
  );

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    prem_d      = prem_q;
    qacc_d      = qacc_q;
    dvsr_d      = dvsr_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    neg_quo_d   = neg_quo_q;
    neg_rem_d   = neg_rem_q;
    dbz_d       = dbz_q;
    dvd_neg     = sgn_mode & dividend[DIV_WIDTH-1];
    dvs_neg     = sgn_mode & divisor[DIV_WIDTH-1];

    unique case (state_q)
      IDLE: begin
        if (start_div) begin
          if (divisor == '0) begin
            dbz_d   = 1'b1;
            state_d = DONE;
          end else begin
            dbz_d     = 1'b0;
            state_d   = CALC;
            count_d   = CNT_WIDTH'(DIV_ITERS - 1);
            prem_d    = '0;
            qacc_d    = cond_negate(dividend, dvd_neg);
            dvsr_d    = cond_negate(divisor, dvs_neg);
            neg_quo_d = dvd_neg ^ dvs_neg;
            neg_rem_d = dvd_neg;
          end
        end
      end
      CALC: begin
        prem_d  = step_rem;
        qacc_d  = {qacc_q[DIV_WIDTH-2:0], step_bit};
        count_d = count_q - 1'b1;
        if (count_q == '0) begin
          state_d = FIX;
        end
      end
      FIX: begin
        quotient_d  = cond_negate(qacc_q, neg_quo_q);
        remainder_d = cond_negate(prem_q, neg_rem_q);
        state_d     = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Flush wins over everything, including a same-cycle start request or a pending FIX write.
    if (flush) begin
      state_d     = IDLE;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      count_q     <= '0;
      prem_q      <= '0;
      qacc_q      <= '0;
      dvsr_q      <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      prem_q      <= prem_d;
      qacc_q      <= qacc_d;
      dvsr_q      <= dvsr_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      neg_quo_q   <= neg_quo_d;
      neg_rem_q   <= neg_rem_d;
      dbz_q       <= dbz_d;
    end
  end

  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign busy      = (state_q != IDLE);
  assign done_div  = (state_q == DONE);
  assign DivByZero = done_div & dbz_q;

endmodule

// File: tb/tb_multicycle_divider.sv
// Self-checking bench for multicycle_divider: directed corner cases plus randomized back-to-back divides.
module tb_multicycle_divider;

`ifdef MULTICYCLE_DIVIDER_SIGNED_EN
  localparam bit SignedEn = 1'b1;
`else
  localparam bit SignedEn = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        start_div;
  logic        signed_div;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        flush;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        done_div;
  logic        busy;
  logic        DivByZero;

  int checks;
  int errors;
  logic [31:0] last_q;
  logic [31:0] last_r;

  multicycle_divider dut (
    .clk        (clk),
    .rst        (rst),
    .start_div  (start_div),
    .signed_div (signed_div),
    .dividend   (dividend),
    .divisor    (divisor),
    .flush      (flush),
    .quotient   (quotient),
    .remainder  (remainder),
    .done_div   (done_div),
    .busy       (busy),
    .DivByZero  (DivByZero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain language-level division; 64-bit signed math makes MIN/-1 wrap naturally.
  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic s);
    longint sa, sb;
    logic [31:0] q, r;
    if (s && SignedEn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = 32'(sa / sb);
      r  = 32'(sa % sb);
    end else begin
      q = a / b;
      r = a % b;
    end
    return {q, r};
  endfunction

  // Drives one request from a negedge and observes until the cycle after completion.
  task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic s,
                        output int dcyc, output int dcnt, output logic [31:0] q,
                        output logic [31:0] r, output logic dz, output logic [31:0] q_hold);
    int cyc;
    dcyc = -1; dcnt = 0; q = '0; r = '0; dz = 1'b0; q_hold = '0;
    dividend = a; divisor = b; signed_div = s; start_div = 1'b1;
    @(posedge clk);
    cyc = 0;
    while (cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        start_div  = 1'b0;
        dividend   = $urandom;
        divisor    = $urandom;
        signed_div = 1'($urandom);
      end
      if (done_div) begin
        dcnt++;
        if (dcyc < 0) begin
          dcyc = cyc; q = quotient; r = remainder; dz = DivByZero;
        end
      end
      if (dcyc >= 0 && cyc == dcyc + 1) begin
        q_hold = quotient;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #1;
    checks += 5;
    if (quotient !== 32'h0) begin errors++; $display("FAIL reset_quotient got %h exp 0", quotient); end
    if (remainder !== 32'h0) begin errors++; $display("FAIL reset_remainder got %h exp 0", remainder); end
    if (done_div !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done_div); end
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    if (DivByZero !== 1'b0) begin errors++; $display("FAIL reset_dbz got %b exp 0", DivByZero); end
    @(negedge clk);
    rst = 1'b0;
    last_q = '0; last_r = '0;
    @(negedge clk);
  endtask

  task automatic test_unsigned_basic;
    int dcyc, dcnt; logic [31:0] q, r, qh; logic dz;
    launch(32'd100, 32'd7, 1'b0, dcyc, dcnt, q, r, dz, qh);
    checks += 6;
    if (dcyc != 34) begin errors++; $display("FAIL udiv_latency got %0d exp 34", dcyc); end
    if (dcnt != 1) begin errors++; $display("FAIL udiv_done_count got %0d exp 1", dcnt); end
    if (q !== 32'd14) begin errors++; $display("FAIL udiv_quotient got %h exp %h", q, 32'd14); end
    if (r !== 32'd2) begin errors++; $display("FAIL udiv_remainder got %h exp %h", r, 32'd2); end
    if (dz !== 1'b0) begin errors++; $display("FAIL udiv_dbz got %b exp 0", dz); end
    if (qh !== 32'd14) begin errors++; $display("FAIL udiv_hold got %h exp %h", qh, 32'd14); end
    last_q = 32'd14; last_r = 32'd2;
  endtask

  task automatic test_signed;
    int dcyc, dcnt; logic [31:0] q, r, qh, eq, er; logic dz;
    eq = SignedEn ? 32'hFFFF_FFFD : 32'h7FFF_FFFC;
    er = SignedEn ? 32'hFFFF_FFFF : 32'h0000_0001;
    launch(32'hFFFF_FFF9, 32'd2, 1'b1, dcyc, dcnt, q, r, dz, qh);
    checks += 3;
    if (dcyc != 34) begin errors++; $display("FAIL sdiv_latency got %0d exp 34", dcyc); end
    if (q !== eq) begin errors++; $display("FAIL sdiv_quotient got %h exp %h", q, eq); end
    if (r !== er) begin errors++; $display("FAIL sdiv_remainder got %h exp %h", r, er); end
    eq = SignedEn ? 32'h8000_0000 : 32'h0000_0000;
    er = SignedEn ? 32'h0000_0000 : 32'h8000_0000;
    launch(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, dcyc, dcnt, q, r, dz, qh);
    checks += 4;
    if (dcyc != 34) begin errors++; $display("FAIL ovf_latency got %0d exp 34", dcyc); end
    if (q !== eq) begin errors++; $display("FAIL ovf_quotient got %h exp %h", q, eq); end
    if (r !== er) begin errors++; $display("FAIL ovf_remainder got %h exp %h", r, er); end
    if (dz !== 1'b0) begin errors++; $display("FAIL ovf_dbz got %b exp 0", dz); end
    last_q = eq; last_r = er;
  endtask

  task automatic test_div_zero;
    int dcyc, dcnt; logic [31:0] q, r, qh; logic dz;
    launch(32'd5, 32'd0, 1'b0, dcyc, dcnt, q, r, dz, qh);
    checks += 5;
    if (dcyc != 1) begin errors++; $display("FAIL dbz_latency got %0d exp 1", dcyc); end
    if (dcnt != 1) begin errors++; $display("FAIL dbz_done_count got %0d exp 1", dcnt); end
    if (dz !== 1'b1) begin errors++; $display("FAIL dbz_flag got %b exp 1", dz); end
    if (q !== last_q) begin errors++; $display("FAIL dbz_quotient got %h exp %h", q, last_q); end
    if (r !== last_r) begin errors++; $display("FAIL dbz_remainder got %h exp %h", r, last_r); end
  endtask

  task automatic test_start_ignored;
    int seen;
    seen = 0;
    dividend = 32'd1000; divisor = 32'd9; signed_div = 1'b0; start_div = 1'b1;
    @(posedge clk);
    for (int cyc = 1; cyc <= 33; cyc++) begin
      @(negedge clk);
      dividend = $urandom;
      divisor  = $urandom;
      if (done_div) seen++;
      if (cyc == 33) start_div = 1'b0;
    end
    @(negedge clk);
    checks += 4;
    if (seen != 0) begin errors++; $display("FAIL held_start_early_done got %0d exp 0", seen); end
    if (done_div !== 1'b1) begin errors++; $display("FAIL held_start_done got %b exp 1", done_div); end
    if (quotient !== 32'd111) begin errors++; $display("FAIL held_start_q got %h exp %h", quotient, 32'd111); end
    if (remainder !== 32'd1) begin errors++; $display("FAIL held_start_r got %h exp %h", remainder, 32'd1); end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL held_start_idle got %b exp 0", busy); end
    last_q = 32'd111; last_r = 32'd1;
  endtask

  task automatic test_flush;
    int seen; logic busy10;
    seen = 0; busy10 = 1'b0;
    dividend = 32'd200; divisor = 32'd3; signed_div = 1'b0; start_div = 1'b1;
    @(posedge clk);
    for (int cyc = 1; cyc <= 10; cyc++) begin
      @(negedge clk);
      if (cyc == 1) start_div = 1'b0;
      if (done_div) seen++;
      if (cyc == 10) begin busy10 = busy; flush = 1'b1; end
    end
    @(negedge clk);
    flush = 1'b0;
    checks += 4;
    if (busy10 !== 1'b1) begin errors++; $display("FAIL flush_busy_before got %b exp 1", busy10); end
    if (busy !== 1'b0) begin errors++; $display("FAIL flush_idle got %b exp 0", busy); end
    if (quotient !== last_q) begin errors++; $display("FAIL flush_q got %h exp %h", quotient, last_q); end
    if (remainder !== last_r) begin errors++; $display("FAIL flush_r got %h exp %h", remainder, last_r); end
    repeat (40) begin
      @(negedge clk);
      if (done_div || busy) seen++;
    end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL flush_no_done got %0d exp 0", seen); end
    dividend = 32'd50; divisor = 32'd5; start_div = 1'b1; flush = 1'b1;
    @(negedge clk);
    start_div = 1'b0; flush = 1'b0;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL flush_start_drop got %b exp 0", busy); end
  endtask

  task automatic test_reset_mid;
    int dcyc, dcnt; logic [31:0] q, r, qh; logic dz;
    dividend = 32'd77; divisor = 32'd4; signed_div = 1'b0; start_div = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_div = 1'b0;
    repeat (14) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks += 5;
    if (quotient !== 32'h0) begin errors++; $display("FAIL midrst_q got %h exp 0", quotient); end
    if (remainder !== 32'h0) begin errors++; $display("FAIL midrst_r got %h exp 0", remainder); end
    if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b exp 0", busy); end
    if (done_div !== 1'b0) begin errors++; $display("FAIL midrst_done got %b exp 0", done_div); end
    if (DivByZero !== 1'b0) begin errors++; $display("FAIL midrst_dbz got %b exp 0", DivByZero); end
    @(negedge clk);
    rst = 1'b0;
    last_q = '0; last_r = '0;
    @(negedge clk);
    launch(32'd1000, 32'd3, 1'b0, dcyc, dcnt, q, r, dz, qh);
    checks += 3;
    if (dcyc != 34) begin errors++; $display("FAIL postrst_latency got %0d exp 34", dcyc); end
    if (q !== 32'd333) begin errors++; $display("FAIL postrst_q got %h exp %h", q, 32'd333); end
    if (r !== 32'd1) begin errors++; $display("FAIL postrst_r got %h exp %h", r, 32'd1); end
    last_q = 32'd333; last_r = 32'd1;
  endtask

  task automatic test_back_to_back;
    int dcyc, dcnt, ecyc; logic [31:0] q, r, qh, a, b, eq, er; logic dz, s;
    logic [63:0] m;
    for (int i = 0; i < 24; i++) begin
      a = $urandom;
      s = 1'($urandom);
      case ($urandom_range(0, 5))
        0:       b = 32'd0;
        1, 2:    b = $urandom_range(1, 20);
        3:       b = 32'h0 - 32'($urandom_range(1, 20));
        default: b = $urandom;
      endcase
      if (b == 32'd0) begin
        eq = last_q; er = last_r; ecyc = 1;
      end else begin
        m = model(a, b, s); eq = m[63:32]; er = m[31:0]; ecyc = 34;
      end
      launch(a, b, s, dcyc, dcnt, q, r, dz, qh);
      checks += 5;
      if (dcyc != ecyc) begin errors++; $display("FAIL b2b_latency[%0d] got %0d exp %0d", i, dcyc, ecyc); end
      if (dcnt != 1) begin errors++; $display("FAIL b2b_done_count[%0d] got %0d exp 1", i, dcnt); end
      if (q !== eq) begin errors++; $display("FAIL b2b_q[%0d] %h/%h s=%b got %h exp %h", i, a, b, s, q, eq); end
      if (r !== er) begin errors++; $display("FAIL b2b_r[%0d] %h/%h s=%b got %h exp %h", i, a, b, s, r, er); end
      if (dz !== (b == 32'd0)) begin errors++; $display("FAIL b2b_dbz[%0d] got %b exp %b", i, dz, (b == 32'd0)); end
      last_q = eq; last_r = er;
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    last_q = '0; last_r = '0;
    rst = 1'b0; start_div = 1'b0; signed_div = 1'b0; flush = 1'b0;
    dividend = '0; divisor = '0;
    #1;
    test_reset();
    test_unsigned_basic();
    test_div_zero();
    test_signed();
    test_start_ignored();
    test_reset_mid();
    test_flush();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_divider.md
MULTICYCLE_DIVIDER -- requirements
Module: multicycle_divider

Interface
REQ-001 SHALL have ports: clk  input  1  sole clock, all state on rising edge.
REQ-002 SHALL have ports: rst  input  1  asynchronous, active-high reset.
REQ-003 SHALL have ports: start_div  input  1  request from decode stage to begin a divide.
REQ-004 SHALL have ports: signed_div  input  1  1 = DIV (two's complement), 0 = DIVU.
REQ-005 SHALL have ports: dividend, divisor  input  32 each  operands (rs, rt), sampled only on the accepting edge.
REQ-006 SHALL have ports: flush  input  1  abort from the pipeline (exception or interrupt).
REQ-007 SHALL have ports: quotient, remainder  output  32 each  registered LO and HI results.
REQ-008 SHALL have ports: done_div  output  1  one-cycle completion pulse, consumed by the stall logic.
REQ-009 SHALL have ports: busy  output  1  high whenever state is not IDLE.
REQ-010 SHALL have ports: DivByZero  output  1  high together with done_div when the latched divisor was 0.

Function
REQ-011 SHALL implement states IDLE, CALC, FIX and DONE.
REQ-012 SHALL accept a request only when start_div=1 and state=IDLE; that rising edge is edge 0.
REQ-013 SHALL latch absolute-value operands, the sign flags and signed_div at edge 0, then enter CALC with the iteration counter set to 31.
REQ-014 SHALL perform one restoring shift/subtract step per CALC cycle, for 32 cycles, and enter FIX at edge 32.
REQ-015 SHALL apply signs in FIX: quotient negated if the operand signs differ, remainder takes the dividend's sign; unsigned mode applies no correction; then enter DONE at edge 33.
REQ-016 SHALL drive done_div=1 for exactly the DONE cycle (cycle 34), with quotient and remainder already valid; DONE returns to IDLE at the next edge.
REQ-017 SHALL, if the divisor is 0 at acceptance, go directly to DONE (done_div and DivByZero high in cycle 1) and leave quotient and remainder unchanged.
REQ-018 SHALL hold quotient and remainder stable from the DONE cycle until the next completed divide.
REQ-019 SHALL ignore start_div while busy=1.
REQ-020 SHALL, on flush=1 in any state, return to IDLE at the next edge with no done_div and outputs unchanged; when flush and start_div are high in the same cycle, flush wins and the request is dropped.
REQ-021 SHALL produce 0x80000000 / 0xFFFFFFFF (signed) = quotient 0x80000000, remainder 0, with no trap (wrap-around).
REQ-022 SHALL allow start_div in the cycle immediately after DONE (back-to-back divides).

Reset
REQ-023 SHALL, on asserting rst, immediately force state=IDLE, counter=0, quotient=0, remainder=0, done_div=0, busy=0, DivByZero=0; an operation in flight is discarded.

Configuration
REQ-024 SHALL honour the macro MULTICYCLE_DIVIDER_SIGNED_EN: defined -> signed_div selects signed or unsigned behaviour; undefined -> signed_div is ignored, every divide is unsigned, and FIX is a pass-through that still takes one cycle (latency unchanged).

Structure
REQ-025 SHALL place the state enum, DIV_WIDTH=32 and DIV_ITERS=32 in shared package div_pkg.
REQ-026 SHALL implement the single restoring step (partial remainder, divisor -> next remainder, quotient bit) as combinational sub-module div_step, instantiated once.

Verification
REQ-027 SHALL cover: unsigned 100/7 started at edge 0 -> done_div only in cycle 34, quotient=14, remainder=2, DivByZero=0.
REQ-028 SHALL cover: signed -7/2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF; with the macro undefined -> quotient 0x7FFFFFFC, remainder 1.
REQ-029 SHALL cover: 5/0 -> done_div and DivByZero high in cycle 1, quotient and remainder keep their previous values.
REQ-030 SHALL cover: flush in cycle 10 of a divide -> IDLE in cycle 11, no done_div; start_div held during CALC -> ignored.
REQ-031 SHALL cover: rst asserted mid-CALC -> all outputs 0 asynchronously; next divide completes correctly after 34 cycles.
